// File: rtl/hazard_scoreboard_if.sv
// D-stage to hazard scoreboard bundle: pre-decoded operand/result fields flow in,
// pipeline enables, bubble control and D-stage forward selects flow back.
interface hazard_scoreboard_if #(
   parameter int NSTAGE = 3,
   parameter int REGW   = 5,
   parameter int TW     = 2
);
   localparam int SELW = $clog2(NSTAGE + 1);

   logic            d_valid;
   logic [REGW-1:0] d_rs;
   logic [REGW-1:0] d_rt;
   logic            d_use_rs;
   logic            d_use_rt;
   logic [TW-1:0]   d_tuse_rs;
   logic [TW-1:0]   d_tuse_rt;
   logic [REGW-1:0] d_dst;
   logic [TW-1:0]   d_tnew;
   logic [1:0]      d_md_kind;
   logic            flush;

   logic            stall;
   logic            pc_en;
   logic            ir_d_en;
   logic            ir_e_clr;
   logic [SELW-1:0] fwd_rs_sel;
   logic [SELW-1:0] fwd_rt_sel;
   logic            md_busy;

   modport master (
      output d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
             d_dst, d_tnew, d_md_kind, flush,
      input  stall, pc_en, ir_d_en, ir_e_clr, fwd_rs_sel, fwd_rt_sel, md_busy
   );

   modport slave (
      input  d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
             d_dst, d_tnew, d_md_kind, flush,
      output stall, pc_en, ir_d_en, ir_e_clr, fwd_rs_sel, fwd_rt_sel, md_busy
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard: tracks in-flight destinations and their remaining
// result latency, plus a HI/LO busy counter, to drive stalls and D-stage forwarding.
module hazard_scoreboard #(
   parameter int NSTAGE  = 3,
   parameter int REGW    = 5,
   parameter int TW      = 2,
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10,
   parameter int CNTW    = 4
)(
   input logic                clk,
   input logic                reset,
   hazard_scoreboard_if.slave bus
);
   localparam int SELW = $clog2(NSTAGE + 1);
   localparam logic [CNTW-1:0] MUL_LOAD = CNTW'(MUL_LAT);
   localparam logic [CNTW-1:0] DIV_LOAD = CNTW'(DIV_LAT);

   typedef enum logic [1:0] {
      MD_NONE   = 2'd0,
      MD_MULT   = 2'd1,
      MD_DIV    = 2'd2,
      MD_ACCESS = 2'd3
   } mdKind_t;

   logic [REGW-1:0] r_dst  [NSTAGE];
   logic [TW-1:0]   r_tnew [NSTAGE];
   logic [CNTW-1:0] r_busy;

   logic            w_rsHit;
   logic [SELW-1:0] w_rsSel;
   logic [TW-1:0]   w_rsTnew;
   logic            w_rtHit;
   logic [SELW-1:0] w_rtSel;
   logic [TW-1:0]   w_rtTnew;
   logic            w_hazRs;
   logic            w_hazRt;
   logic            w_hazMd;
   logic            w_mdBusy;
   logic            w_stall;
   logic            w_issue;
   mdKind_t         w_mdKind;

   assign w_mdKind = mdKind_t'(bus.d_md_kind);

   // Scan oldest to youngest so the youngest matching slot overwrites older hits.
   always_comb begin
      w_rsHit  = 1'b0;
      w_rsSel  = '0;
      w_rsTnew = '0;
      w_rtHit  = 1'b0;
      w_rtSel  = '0;
      w_rtTnew = '0;
      for (int k = NSTAGE - 1; k >= 0; k--) begin
         if (bus.d_use_rs && (bus.d_rs != '0) && (r_dst[k] == bus.d_rs)) begin
            w_rsHit  = 1'b1;
            w_rsSel  = SELW'(k + 1);
            w_rsTnew = r_tnew[k];
         end
         if (bus.d_use_rt && (bus.d_rt != '0) && (r_dst[k] == bus.d_rt)) begin
            w_rtHit  = 1'b1;
            w_rtSel  = SELW'(k + 1);
            w_rtTnew = r_tnew[k];
         end
      end
   end

   assign w_hazRs  = w_rsHit && (w_rsTnew > bus.d_tuse_rs);
   assign w_hazRt  = w_rtHit && (w_rtTnew > bus.d_tuse_rt);
   assign w_mdBusy = (r_busy != '0);
   assign w_hazMd  = bus.d_valid && (w_mdKind != MD_NONE) && w_mdBusy;
   assign w_stall  = bus.d_valid && (w_hazRs || w_hazRt || w_hazMd);
   assign w_issue  = bus.d_valid && !w_stall && !bus.flush;

   assign bus.stall      = w_stall;
   assign bus.pc_en      = !w_stall;
   assign bus.ir_d_en    = !w_stall;
   assign bus.ir_e_clr   = w_stall || bus.flush;
   assign bus.fwd_rs_sel = w_rsSel;
   assign bus.fwd_rt_sel = w_rtSel;
   assign bus.md_busy    = w_mdBusy;

   // A stalled or flushed D stage enters E as a bubble (dst 0).
   always_ff @(posedge clk) begin
      if (!reset || bus.flush) begin
         for (int k = 0; k < NSTAGE; k++) begin
            r_dst[k]  <= '0;
            r_tnew[k] <= '0;
         end
      end else begin
         r_dst[0]  <= w_issue ? bus.d_dst  : '0;
         r_tnew[0] <= w_issue ? bus.d_tnew : '0;
         for (int k = 1; k < NSTAGE; k++) begin
            r_dst[k]  <= r_dst[k-1];
            r_tnew[k] <= (r_tnew[k-1] == '0) ? '0 : (r_tnew[k-1] - 1'b1);
         end
      end
   end

   // Flush deliberately leaves the counter alone: a started mult/div always completes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_busy <= '0;
      end else if (w_issue && (w_mdKind == MD_MULT)) begin
         r_busy <= MUL_LOAD;
      end else if (w_issue && (w_mdKind == MD_DIV)) begin
         r_busy <= DIV_LOAD;
      end else if (w_mdBusy) begin
         r_busy <= r_busy - 1'b1;
      end
   end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised, stateful hazard controller for the pipelined MIPS core. It replaces per-opcode stall and forward decoding with a Tuse/Tnew scoreboard: a shift register of in-flight destination registers and their remaining result latency across NSTAGE post-decode stages. It also owns a multi-cycle HI/LO (mult/div) busy counter and a flush path for exceptions and eret. It sits beside the D stage, consumes pre-decoded fields from the D-stage controller, and drives PC/IR_D enables, the IR_E clear, and the D-stage forward selects.

## Interface
- NSTAGE, 3: tracked stages after D (slot 0 = E, slot 1 = M, slot 2 = W).
- REGW, 5: register index width.
- TW, 2: Tuse/Tnew width.
- MUL_LAT, 5: HI/LO busy cycles for mult/multu.
- DIV_LAT, 10: HI/LO busy cycles for div/divu.
- CNTW, 4: busy counter width; must satisfy 2^CNTW > max(MUL_LAT, DIV_LAT).
- SELW (derived) = clog2(NSTAGE+1).
- Reset is synchronous and active-low.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low.
- d_valid  in  1  the D stage holds a real instruction.
- d_rs, d_rt  in  REGW  source register indices.
- d_use_rs, d_use_rt  in  1  the source is actually read.
- d_tuse_rs, d_tuse_rt  in  TW  cycles from D until the operand is needed (0 = needed in D).
- d_dst  in  REGW  destination register; 0 = no write.
- d_tnew  in  TW  cycles after entering E until the result is forwardable.
- d_md_kind  in  2  0 = none, 1 = mult start, 2 = div start, 3 = HI/LO access (mfhi/mflo/mthi/mtlo).
- flush  in  1  exception or eret; kills all in-flight slots.
- stall  out  1  hold D, inject a bubble into E.
- pc_en, ir_d_en  out  1  = !stall.
- ir_e_clr  out  1  = stall | flush.
- fwd_rs_sel, fwd_rt_sel  out  SELW  0 = register file; k+1 = forward from slot k.
- md_busy  out  1  busy counter is non-zero.

## Operation
- Each slot k holds {dst[REGW], tnew[TW]}. A bubble is dst = 0.
- Every cycle, all slots shift: slot k ← slot k−1 with tnew' = (tnew==0) ? 0 : tnew−1. The last slot's contents drop off.
- Slot 0 loads {d_dst, d_tnew} when issue = d_valid & !stall & !flush. Otherwise slot 0 loads a bubble.
- Match for rs: d_use_rs & d_rs != 0 & slot k dst == d_rs. Only the youngest matching slot (smallest k) counts. rt uses the same rule.
- Stall sources:
  - haz_rs: the youngest match has tnew > d_tuse_rs. haz_rt is the same for rt.
  - haz_md: d_valid & d_md_kind != 0 & md_busy.
  - stall = d_valid & (haz_rs | haz_rt | haz_md).
- fwd_rs_sel = k+1 of the youngest match, else 0. It is computed even while stalling; downstream ignores it then. fwd_rt_sel works the same way.
- Busy counter:
  - Loads MUL_LAT on issue with kind 1, or DIV_LAT on issue with kind 2.
  - Otherwise it decrements toward 0 and saturates at 0.
  - flush does not clear it; a started HI/LO operation always completes.
- flush: all slots become bubbles on the next edge and no issue occurs that cycle. It has priority over issue.
- $0 never matches, so it never stalls or forwards.

## Timing
- Reset (reset low at an edge): all slots are bubbles and the counter is 0. The following cycle, stall=0, pc_en=1, ir_d_en=1, ir_e_clr=flush, fwd selects=0, md_busy=0.
- stall, enables and selects are combinational from current state and the D inputs, with zero-cycle latency.
- Scoreboard update latency is 1 cycle: an instruction issued at edge t is visible in slot 0 from t+1.
- HI/LO busy window: kind 1/2 issued at edge t gives md_busy=1 for cycles t+1 … t+LAT. A dependent HI/LO access issues at edge t+LAT+1.
- Simultaneous flush and stall: ir_e_clr=1, slots clear, and stall drops the next cycle unless haz_md holds.
- reset asserted mid-divide: the counter is forced to 0 at that edge.

## Test plan
- Load-use: lw $8 (tnew=2) issues, then addu with rs=$8 (tuse=1). Required: stall=1 for exactly 1 cycle, then stall=0 with fwd_rs_sel=2.
- Branch: addu $9 (tnew=1), then beq with rs=$9 (tuse=0). Required: 1 stall cycle, then fwd_rs_sel=2. With a lw producer instead, 2 stall cycles.
- Youngest wins: slot 0 and slot 1 both dst=$9, tnew=0, and D reads rt=$9 (tuse=0). Required: fwd_rt_sel=1, stall=0.
- $0 and unused operands: a producer with dst=0 and d_rs=0, plus d_use_rt=0 with a matching rt. Required: stall=0 and both fwd selects 0.
- HI/LO: mult issues, then mflo waits in D. Required: md_busy=1 and stall=1 for 5 cycles, issue on the 6th. Same with div gives 10 cycles.
- Flush/reset: flush during a load-use stall gives ir_e_clr=1 and all selects 0 next cycle. reset low on cycle 3 of a div gives md_busy=0 the next cycle.
